// File: rtl/regfile_multiport.sv
// Multi-port register file with optional registered read, write-first bypass,
// hardwired-zero register 0 and a multi-cycle hardware clear sequencer.
module regfile_multiport #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int NB_READ      = 2,
    parameter int READ_LATENCY = 0,
    parameter int BYPASS       = 1,
    parameter int ZERO_REG     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         W,
    input  logic                          Wen,
    input  logic [ADDR_WIDTH-1:0]         WA,
    input  logic [NB_READ*ADDR_WIDTH-1:0] RA,
    output logic [NB_READ*DATA_WIDTH-1:0] RD,
    input  logic                          Clr,
    output logic                          Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_next;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_busy;
    logic                    w_wr_en;
    logic [NB_READ*DATA_WIDTH-1:0] w_rd;

    assign w_busy  = (r_state == S_CLEAR);
    assign w_wr_en = Wen && !w_busy && !((ZERO_REG != 0) && (WA == '0));
    assign Busy    = w_busy;

    // Clear sequencer state and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state: walk every address once, then return to idle
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (Clr) begin
                    w_state_next = S_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            S_CLEAR: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Storage: clearing has priority, normal writes only when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[WA] <= W;
        end
    end

    // Per-port read value with zero register and write-first bypass
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NB_READ; i++) begin
            if ((ZERO_REG != 0) && (RA[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                w_rd[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS != 0) && !w_busy && Wen &&
                         (WA == RA[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_rd[i*DATA_WIDTH +: DATA_WIDTH] = W;
            end else begin
                w_rd[i*DATA_WIDTH +: DATA_WIDTH] =
                    r_mem[RA[i*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_rd_reg
            logic [NB_READ*DATA_WIDTH-1:0] r_rd;

            // Registered read data, one cycle behind the address
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd <= '0;
                end else begin
                    r_rd <= w_rd;
                end
            end

            assign RD = r_rd;
        end else begin : g_rd_comb
            assign RD = w_rd;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: four configurations share one stimulus stream
// and are compared against an array-based reference model.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  W;
    logic        Wen;
    logic [3:0]  WA;
    logic [3:0]  ra0, ra1;
    logic [7:0]  RA;
    logic        Clr;
    logic [15:0] rd_a, rd_b, rd_c, rd_d;
    logic        busy_a, busy_b, busy_c, busy_d;

    assign RA = {ra1, ra0};

    always #5 clk = ~clk;

    regfile_multiport u_byp (
        .clk(clk), .rst_n(rst_n), .W(W), .Wen(Wen), .WA(WA),
        .RA(RA), .RD(rd_a), .Clr(Clr), .Busy(busy_a)
    );

    regfile_multiport #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .W(W), .Wen(Wen), .WA(WA),
        .RA(RA), .RD(rd_b), .Clr(Clr), .Busy(busy_b)
    );

    regfile_multiport #(.READ_LATENCY(1)) u_lat (
        .clk(clk), .rst_n(rst_n), .W(W), .Wen(Wen), .WA(WA),
        .RA(RA), .RD(rd_c), .Clr(Clr), .Busy(busy_c)
    );

    regfile_multiport #(.ZERO_REG(1)) u_zero (
        .clk(clk), .rst_n(rst_n), .W(W), .Wen(Wen), .WA(WA),
        .RA(RA), .RD(rd_d), .Clr(Clr), .Busy(busy_d)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mdl [16];
    int         clr_idx;
    logic [7:0] exp_l1 [2];

    typedef struct {
        logic       wen;
        logic [3:0] wa;
        logic [7:0] w;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [7:0] val(bit byp, bit zr, logic [3:0] a);
        if (zr && a == 4'd0) return 8'h00;
        if (byp && clr_idx < 0 && Wen && WA == a) return W;
        return mdl[a];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic check_all();
        logic [3:0] a;
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? ra0 : ra1;
            chk($sformatf("bypass rd%0d a=%0d", p, a),
                32'(rd_a[p*8 +: 8]), 32'(val(1'b1, 1'b0, a)));
            chk($sformatf("readold rd%0d a=%0d", p, a),
                32'(rd_b[p*8 +: 8]), 32'(val(1'b0, 1'b0, a)));
            chk($sformatf("latency rd%0d", p),
                32'(rd_c[p*8 +: 8]), 32'(exp_l1[p]));
            chk($sformatf("zeroreg rd%0d a=%0d", p, a),
                32'(rd_d[p*8 +: 8]), 32'(val(1'b1, 1'b1, a)));
        end
        chk("busy", 32'({busy_a, busy_b, busy_c, busy_d}),
            (clr_idx >= 0) ? 32'hF : 32'h0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        clr_idx   = -1;
        exp_l1[0] = 8'h00;
        exp_l1[1] = 8'h00;
    endtask

    task automatic drive(input logic wen, input logic [3:0] wa,
                         input logic [7:0] w, input logic [3:0] a0,
                         input logic [3:0] a1, input logic clr);
        @(negedge clk);
        Wen = wen;
        WA  = wa;
        W   = w;
        ra0 = a0;
        ra1 = a1;
        Clr = clr;
        #1;
        check_all();
    endtask

    task automatic tick();
        if (rst_n) begin
            exp_l1[0] = val(1'b1, 1'b0, ra0);
            exp_l1[1] = val(1'b1, 1'b0, ra1);
        end else begin
            exp_l1[0] = 8'h00;
            exp_l1[1] = 8'h00;
        end
        @(posedge clk);
        if (rst_n) begin
            if (clr_idx >= 0) begin
                mdl[clr_idx] = 8'h00;
                clr_idx++;
                if (clr_idx == 16) clr_idx = -1;
            end else begin
                if (Wen) mdl[WA] = W;
                if (Clr) clr_idx = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        Wen   = 1'b0;
        WA    = 4'd0;
        W     = 8'h00;
        ra0   = 4'd0;
        ra1   = 4'd0;
        Clr   = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_cnt;

        tbl[0]  = '{1'b0, 4'd0, 8'h00, 4'd0,  4'd1, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 4'd0, 8'h00, 4'd15, 4'd8, 8'h00, 8'h00};
        tbl[2]  = '{1'b1, 4'd3, 8'hA5, 4'd3,  4'd3, 8'hA5, 8'hA5};
        tbl[3]  = '{1'b0, 4'd0, 8'h00, 4'd3,  4'd3, 8'hA5, 8'hA5};
        tbl[4]  = '{1'b0, 4'd0, 8'h00, 4'd3,  4'd4, 8'hA5, 8'h00};
        tbl[5]  = '{1'b1, 4'd7, 8'h11, 4'd7,  4'd2, 8'h11, 8'h00};
        tbl[6]  = '{1'b1, 4'd7, 8'h22, 4'd7,  4'd7, 8'h22, 8'h22};
        tbl[7]  = '{1'b0, 4'd0, 8'h00, 4'd7,  4'd3, 8'h22, 8'hA5};
        tbl[8]  = '{1'b1, 4'd2, 8'h5A, 4'd2,  4'd0, 8'h5A, 8'h00};
        tbl[9]  = '{1'b1, 4'd0, 8'hFF, 4'd0,  4'd2, 8'hFF, 8'h5A};
        tbl[10] = '{1'b0, 4'd0, 8'h00, 4'd0,  4'd0, 8'hFF, 8'hFF};

        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0);
            chk($sformatf("post-reset reg%0d", i), 32'(rd_a[7:0]), 32'h0);
            tick();
        end

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].wen, tbl[i].wa, tbl[i].w, tbl[i].a0, tbl[i].a1, 1'b0);
            chk($sformatf("vec%0d rd0", i), 32'(rd_a[7:0]), 32'(tbl[i].e0));
            chk($sformatf("vec%0d rd1", i), 32'(rd_a[15:8]), 32'(tbl[i].e1));
            tick();
        end

        drive(1'b1, 4'd7, 8'h33, 4'd7, 4'd0, 1'b0);
        chk("readold same cycle", 32'(rd_b[7:0]), 32'h22);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd7, 4'd0, 1'b0);
        chk("readold next cycle", 32'(rd_b[7:0]), 32'h33);
        tick();

        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd2, 1'b0);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd2, 1'b0);
        chk("latency rd1 reg2", 32'(rd_c[15:8]), 32'h5A);
        chk("zero reg after write", 32'(rd_d[7:0]), 32'h0);
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 8'(8'h10 + i), 4'(i), 4'd0, 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd15, 1'b1);
        tick();
        busy_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            drive(j == 5, 4'd15, 8'h77, 4'(j), 4'd15, 1'b0);
            if (busy_a) busy_cnt++;
            tick();
        end
        chk("busy cycles", 32'(busy_cnt), 32'd16);
        drive(1'b0, 4'd0, 8'h00, 4'd15, 4'd14, 1'b0);
        chk("reg15 cleared", 32'(rd_a[7:0]), 32'h0);
        chk("busy low after", 32'(busy_a), 32'h0);
        tick();
        drive(1'b1, 4'd9, 8'h3C, 4'd1, 4'd1, 1'b0);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b0);
        chk("write after clear", 32'(rd_a[7:0]), 32'h3C);
        tick();

        drive(1'b1, 4'd14, 8'h66, 4'd14, 4'd15, 1'b0);
        tick();
        drive(1'b1, 4'd15, 8'h99, 4'd14, 4'd15, 1'b0);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd14, 4'd15, 1'b1);
        tick();
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, 4'd0, 8'h00, 4'd14, 4'd15, 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 8'h00, 4'd14, 4'd15, 1'b0);
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("midclear busy", 32'(busy_a), 32'h0);
        chk("midclear rd", 32'(rd_a), 32'h0);
        chk("midclear lat rd", 32'(rd_c), 32'h0);
        check_all();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'd14, 8'h42, 4'd14, 4'd14, 1'b0);
        chk("idle after reset", 32'(busy_a), 32'h0);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd14, 4'd15, 1'b0);
        chk("write after reset", 32'(rd_a[7:0]), 32'h42);
        tick();

        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
                  4'($urandom), 4'($urandom), $urandom_range(0, 39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor of the team's 8-bit, 16-entry, 2-read/1-write register file.
- Adds the following over the previous generation:
  - configurable width, depth and read-port count;
  - optional registered read;
  - optional write-first bypass;
  - optional hardwired-zero register 0;
  - asynchronous reset;
  - a multi-cycle hardware clear sequencer with busy flag.
- Sits in the datapath between the execution unit (W/WA/Wen) and operand fetch (RA/RD); the same formal assertion module binds onto it.

Parameters:
- DATA_WIDTH, 8, bits per register.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH registers.
- NB_READ, 2, number of independent read ports, 1..8.
- READ_LATENCY, 0, 0 = combinational read, 1 = RD registered on clk.
- BYPASS, 1, 1 = write-first (same-cycle write visible on read), 0 = read-old.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- W  in  DATA_WIDTH  write data.
- Wen  in  1  write enable.
- WA  in  ADDR_WIDTH  write address.
- RA  in  NB_READ*ADDR_WIDTH  packed read addresses; port i = RA[i*ADDR_WIDTH +: ADDR_WIDTH].
- RD  out  NB_READ*DATA_WIDTH  packed read data; port i = RD[i*DATA_WIDTH +: DATA_WIDTH].
- Clr  in  1  start hardware clear (sampled on clk).
- Busy  out  1  clear sequence in progress.

Behaviour:
Reset:
- rst_n low: all DEPTH registers = 0; FSM = IDLE; clear counter = 0; Busy = 0.
- RD = 0 when READ_LATENCY=1; RD follows the zeroed array when READ_LATENCY=0.
- Reset takes effect immediately, asynchronously, including mid-clear; release is synchronised to clk by the integrator.

Write:
- In IDLE with Wen=1 at a rising edge: reg[WA] <= W.
- ZERO_REG=1 and WA=0: write discarded.

Read:
- Each port is independent; any number of ports may address the same register.
- READ_LATENCY=0: RD_i = value(RA_i) in the same cycle.
- READ_LATENCY=1: RD_i = value(RA_i) sampled at the edge, visible the next cycle.
- value(a) = 0 if ZERO_REG=1 and a=0.
- Otherwise, if BYPASS=1, Busy=0, Wen=1 and WA=a: value(a) = W.
- Otherwise value(a) = reg[a].

Clear FSM (states IDLE, CLEAR):
- IDLE, Clr=1 at edge: go to CLEAR, counter <= 0. Any write in that same cycle is still performed (it is cleared later).
- CLEAR, each edge: reg[counter] <= 0, counter <= counter+1.
- When counter = DEPTH-1: go to IDLE and counter <= 0.
- Busy = 1 exactly while in CLEAR, so it is high for DEPTH cycles.
- While Busy: Wen is ignored (write dropped, no bypass), Clr is ignored, and reads return current array contents (partially cleared).
- Clr held high across the return to IDLE starts a new sequence on the next edge.

Widths and indexing:
- Address is always in range (DEPTH = 2**ADDR_WIDTH), so no wrap handling is needed.
- The counter is ADDR_WIDTH bits and wraps naturally at DEPTH-1.

Test Plan:
All scenarios use defaults DATA_WIDTH=8, ADDR_WIDTH=4, NB_READ=2 unless stated.

1. Reset then write/read:
   - Stimulus: rst_n low 2 cycles, release; read all 16 addresses; write 0xA5 to reg 3; read reg 3 on both ports.
   - Required: all reads 0 before the write; reg 3 reads 0xA5 on both ports; other registers stay 0.
2. Bypass:
   - Stimulus: reg 7 = 0x11; in one cycle Wen=1, WA=7, W=0x22, RA0=7.
   - Required: BYPASS=1 gives RD0=0x22 that cycle. BYPASS=0 gives 0x11 that cycle, then 0x22 the next.
3. Registered read (READ_LATENCY=1):
   - Stimulus: reg 2 = 0x5A; RA1 changes 0→2.
   - Required: RD1 shows 0x5A exactly one cycle later; RD1 = 0 directly after reset.
4. Zero register (ZERO_REG=1):
   - Stimulus: write 0xFF to reg 0 with RA0=0.
   - Required: RD0 = 0 in the write cycle and afterwards.
5. Hardware clear:
   - Stimulus: fill regs 0..15 with 0x10+i; pulse Clr.
   - Required: Busy high for 16 cycles; reg k reads 0 from cycle k+1; Wen=1 to reg 15 at cycle 5 is dropped; reg 15 = 0 at end; Busy low afterwards; a new write is accepted.
6. Reset mid-clear:
   - Stimulus: rst_n low during CLEAR cycle 6 (async, between edges).
   - Required: Busy=0 and all registers 0 immediately; FSM in IDLE after release.
